// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the parametrised pipeline stage register.
// State codes and kill-priority rules common to every stage instance.
package pipe_skid_reg_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Kill priority, highest first:
    //   RESET : everything to reset values, stall counter cleared.
    //   Req   : held and incoming beats dropped; counter kept.
    //   flush : held beats dropped; a beat accepted this cycle survives.
    //   none  : normal valid/ready skid operation.
    // A beat leaving on out_fire in a kill cycle counts as delivered.
    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg_sat_counter.sv
// Saturating up-counter with synchronous reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (RESET) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with 2-entry skid store and kill support.
// in_ready and out_valid come straight from flops.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH            = 32,
    parameter int               ADDR_W           = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VALUE     = '0,
    parameter bit               KEEP_ADDR_ON_REQ = 1'b0,
    parameter int               CNT_W            = 16
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              Req,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  stall_cnt
);

    skid_state_t       state, state_n;
    logic [WIDTH-1:0]  main_data, main_data_n;
    logic [ADDR_W-1:0] main_addr, main_addr_n;
    logic [WIDTH-1:0]  skid_data, skid_data_n;
    logic [ADDR_W-1:0] skid_addr, skid_addr_n;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_data;
    assign out_addr = main_addr;

    always_comb begin
        state_n     = state;
        main_data_n = main_data;
        main_addr_n = main_addr;
        skid_data_n = skid_data;
        skid_addr_n = skid_addr;
        if (Req) begin
            state_n     = S_EMPTY;
            main_data_n = BUBBLE_VALUE;
            main_addr_n = KEEP_ADDR_ON_REQ ? in_addr : '0;
            skid_data_n = BUBBLE_VALUE;
            skid_addr_n = '0;
        end else if (flush) begin
            skid_data_n = BUBBLE_VALUE;
            skid_addr_n = '0;
            if (in_fire) begin
                state_n     = S_ONE;
                main_data_n = in_data;
                main_addr_n = in_addr;
            end else begin
                state_n     = S_EMPTY;
                main_data_n = BUBBLE_VALUE;
                main_addr_n = '0;
            end
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_n     = S_ONE;
                        main_data_n = in_data;
                        main_addr_n = in_addr;
                    end
                end
                S_ONE: begin
                    if (in_fire && !out_fire) begin
                        state_n     = S_TWO;
                        skid_data_n = in_data;
                        skid_addr_n = in_addr;
                    end else if (in_fire && out_fire) begin
                        main_data_n = in_data;
                        main_addr_n = in_addr;
                    end else if (out_fire) begin
                        state_n     = S_EMPTY;
                        main_data_n = BUBBLE_VALUE;
                        main_addr_n = '0;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        state_n     = S_ONE;
                        main_data_n = skid_data;
                        main_addr_n = skid_addr;
                        skid_data_n = BUBBLE_VALUE;
                        skid_addr_n = '0;
                    end
                end
                default: begin
                    state_n     = S_EMPTY;
                    main_data_n = BUBBLE_VALUE;
                    main_addr_n = '0;
                    skid_data_n = BUBBLE_VALUE;
                    skid_addr_n = '0;
                end
            endcase
        end
    end

    // Handshake flags are recomputed from the next state so they stay registered.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state     <= S_EMPTY;
            main_data <= BUBBLE_VALUE;
            main_addr <= '0;
            skid_data <= BUBBLE_VALUE;
            skid_addr <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            main_data <= main_data_n;
            main_addr <= main_addr_n;
            skid_data <= skid_data_n;
            skid_addr <= skid_addr_n;
            in_ready  <= (state_n != S_TWO);
            out_valid <= (state_n != S_EMPTY);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .RESET (RESET),
        .inc   (out_valid & ~out_ready),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: streaming, backpressure, kills,
// reset priority and stall counter saturation.
module tb_pipe_skid_reg;

    localparam logic [31:0] BUB = 32'hBBBB_0000;

    logic        clk = 1'b0;
    logic        RESET, Req, flush;
    logic        in_valid, in_ready;
    logic [31:0] in_data, in_addr;
    logic        out_valid, out_ready;
    logic [31:0] out_data, out_addr;
    logic [2:0]  stall_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .WIDTH            (32),
        .ADDR_W           (32),
        .BUBBLE_VALUE     (BUB),
        .KEEP_ADDR_ON_REQ (1'b1),
        .CNT_W            (3)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .Req       (Req),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .stall_cnt (stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send(input logic [31:0] d, input logic [31:0] a);
        in_valid = 1'b1;
        in_data  = d;
        in_addr  = a;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; Req = 1'b0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; in_addr = '0; out_ready = 1'b0;
        tick();
        RESET = 1'b0;
        chk("rst_ovalid", out_valid, 0);
        chk("rst_iready", in_ready, 1);
        chk("rst_data", out_data, BUB);
        chk("rst_addr", out_addr, 0);
        chk("rst_stall", stall_cnt, 0);

        // stream with out_ready high
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = i;
            in_addr = 32'h100 + 4 * i;
            tick();
            chk("str_valid", out_valid, 1);
            chk("str_data", out_data, i);
            chk("str_addr", out_addr, 32'h100 + 4 * i);
            chk("str_iready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        chk("str_drain_valid", out_valid, 0);
        chk("str_drain_data", out_data, BUB);
        chk("str_stall", stall_cnt, 0);

        // backpressure fill then drain
        out_ready = 1'b0;
        send(32'hA, 32'h200);
        chk("bp_one_data", out_data, 32'hA);
        chk("bp_one_stall", stall_cnt, 0);
        send(32'hB, 32'h204);
        chk("bp_two_iready", in_ready, 0);
        chk("bp_two_data", out_data, 32'hA);
        chk("bp_two_stall", stall_cnt, 1);
        repeat (4) tick();
        chk("bp_stall5", stall_cnt, 5);
        chk("bp_hold_data", out_data, 32'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_dr1_data", out_data, 32'hB);
        chk("bp_dr1_addr", out_addr, 32'h204);
        chk("bp_dr1_iready", in_ready, 1);
        chk("bp_dr1_stall", stall_cnt, 5);
        tick();
        chk("bp_dr2_valid", out_valid, 0);
        chk("bp_dr2_data", out_data, BUB);

        // Req kill from TWO
        out_ready = 1'b0;
        send(32'hA, 32'h300);
        send(32'hB, 32'h304);
        chk("req_pre_iready", in_ready, 0);
        Req = 1'b1; in_valid = 1'b1;
        in_data = 32'hE; in_addr = 32'h3004;
        tick();
        Req = 1'b0; in_valid = 1'b0;
        chk("req_valid", out_valid, 0);
        chk("req_data", out_data, BUB);
        chk("req_addr", out_addr, 32'h3004);
        chk("req_iready", in_ready, 1);
        chk("req_stall_kept", stall_cnt, 7);
        out_ready = 1'b1;
        tick();
        chk("req_no_deliver", out_valid, 0);

        // flush with same-cycle accept
        out_ready = 1'b0;
        send(32'hA, 32'h400);
        flush = 1'b1; in_valid = 1'b1;
        in_data = 32'hC; in_addr = 32'h404;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", out_valid, 1);
        chk("fl_data", out_data, 32'hC);
        chk("fl_addr", out_addr, 32'h404);
        out_ready = 1'b1;
        tick();
        chk("fl_no_a", out_valid, 0);

        // flush in TWO always empties
        out_ready = 1'b0;
        send(32'h11, 32'h500);
        send(32'h12, 32'h504);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h13;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_valid", out_valid, 0);
        chk("fl2_data", out_data, BUB);
        chk("fl2_iready", in_ready, 1);

        // RESET beats Req
        send(32'h21, 32'h600);
        RESET = 1'b1; Req = 1'b1; in_addr = 32'h3004;
        tick();
        RESET = 1'b0; Req = 1'b0;
        chk("pri_valid", out_valid, 0);
        chk("pri_addr", out_addr, 0);
        chk("pri_data", out_data, BUB);
        chk("pri_stall", stall_cnt, 0);

        // stall counter saturation
        out_ready = 1'b0;
        send(32'h31, 32'h700);
        repeat (6) tick();
        chk("sat_6", stall_cnt, 6);
        tick();
        chk("sat_7", stall_cnt, 7);
        repeat (3) tick();
        chk("sat_hold", stall_cnt, 7);
        chk("sat_data", out_data, 32'h31);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
